instr_encoder: RTL
==================

# instr_encoder

Streaming RV32I instruction encoder that packs instruction fields into 32-bit machine words, the inverse of the pipeline's instruction decoder. Each accepted field bundle is range-checked, encoded, and presented with a sequential instruction-memory address. This lets a host-side loader or a test harness fill instruction memory directly from field-level descriptions. It sits between the loader/harness and the instruction-memory write port, with valid/ready handshakes on both sides.

## Interface
- ADDR_W, 32, width of out_addr
- BASE_ADDR, 0, first address emitted after reset or restart (word-aligned)

- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- restart  in  1  synchronous pulse: address returns to BASE_ADDR, error count cleared
- in_valid  in  1  field bundle valid
- in_ready  out  1  bundle accepted when in_valid && in_ready
- fmt  in  3  0=R, 1=I, 2=S, 3=B, 4=U, 5=J, 6..7 illegal
- opcode  in  7  placed in bits [6:0] unchanged
- func3  in  3  funct3
- func7  in  7  funct7 (R format, and I-format shifts)
- rd, rs1, rs2  in  5 each  register indices
- imm  in  32  signed byte-offset/immediate value (U: full 32-bit value)
- out_valid  out  1  encoded word valid
- out_ready  in  1  sink accepts when out_valid && out_ready
- out_instr  out  32  encoded instruction
- out_addr  out  ADDR_W  target address of out_instr
- out_err  out  1  bundle failed its check; out_instr forced to NOP 0x00000013
- err_count  out  16  saturating count of emitted words with out_err=1

## Operation
- Encoding:
  - R: {func7, rs2, rs1, func3, rd, opcode}.
  - I: {imm[11:0], rs1, func3, rd, opcode}.
  - I shift (opcode 0010011 with func3 1 or 5): {func7, imm[4:0], rs1, func3, rd, opcode}.
  - S: {imm[11:5], rs2, rs1, func3, imm[4:0], opcode}.
  - B: {imm[12], imm[10:5], rs2, rs1, func3, imm[4:1], imm[11], opcode}.
  - U: {imm[31:12], rd, opcode}.
  - J: {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode}.
- Error checks (any failure sets out_err=1 and out_instr=0x00000013):
  - I and S: imm signed in -2048..2047.
  - I shift: imm in 0..31.
  - B: imm in -4096..4094 and imm[0]=0.
  - J: imm in -1048576..1048574 and imm[0]=0.
  - U: imm[11:0]=0.
  - fmt 6 or 7: always an error.
  - No check on opcode or funct fields.
- Address counter:
  - Holds the next address; loads BASE_ADDR on reset or restart.
  - Each accepted bundle is tagged with the current value, then the counter adds 4, wrapping modulo 2^ADDR_W.
  - Errored bundles still consume an address.
- err_count increments when an errored word is accepted on the output; it saturates at 0xFFFF.
- Single output register (one-deep pipeline):
  - in_ready = !out_valid || out_ready, which gives full throughput with no bubble under continuous ready.
  - Output register and address counter state: EMPTY (out_valid=0) or FULL (out_valid=1).
  - EMPTY→FULL on input accept.
  - FULL→FULL on a simultaneous output and input transfer; the new word replaces the old in the same edge.
  - FULL→EMPTY on an output transfer with no input accept.
- restart has priority over an input accepted in the same cycle:
  - That bundle is tagged BASE_ADDR and the counter becomes BASE_ADDR+4.
  - A word already held in the output register is not discarded.

## Timing
- Reset values: out_valid=0, out_instr=0x00000013, out_addr=BASE_ADDR, out_err=0, err_count=0, counter=BASE_ADDR. in_ready=1 during and after reset.
- Latency: a bundle accepted on edge N appears on out_* after edge N (registered), valid from cycle N+1.
- While out_valid && !out_ready, out_instr, out_addr and out_err hold stable, and in_ready=0.
- Reset asserted mid-stream drops the held word immediately (asynchronously) and no address advances. After release, the first accepted bundle is tagged BASE_ADDR.
- Inputs are sampled only on accept; field values outside the accept cycle are don't-care.

## Test plan
- R ADD: fmt=0, opcode=0x33, func3=0, func7=0, rd=3, rs1=1, rs2=2 → out_instr=0x002081B3, out_addr=0x0, out_err=0, one cycle later.
- I and U back-to-back with out_ready=1:
  - ADDI rd=1, rs1=0, imm=-1 → 0xFFF00093 at addr 0x0.
  - Then LUI opcode=0x37, rd=5, imm=0x12345000 → 0x123452B7 at addr 0x4.
  - in_ready stays 1 throughout.
- B and range errors:
  - BEQ opcode=0x63, rs1=1, rs2=2, imm=8 → 0x00208463.
  - imm=7 → out_err=1, out_instr=0x00000013, err_count=1.
  - I imm=2048 → err_count=2.
  - The address still advances each time.
- Backpressure: hold out_ready=0 for 5 cycles with in_valid=1 → in_ready=0, output stable and no address skipped. After release, addresses run 0x0, 0x4, 0x8 in order.
- Wrap and restart:
  - With ADDR_W=4 and BASE_ADDR=0xC, two accepts → addresses 0xC then 0x0.
  - A restart pulse then returns the next address to 0xC and clears err_count.
- Reset mid-operation: with out_valid=1 and out_ready=0, assert reset → out_valid=0 at once. After release, the next bundle is tagged BASE_ADDR.

Source files
------------

// File: rtl/instr_encoder.sv
// RV32I field-bundle to machine-word encoder with range checking, sequential
// instruction-memory addressing and a single registered output stage.
module instr_encoder #(
   parameter int unsigned       ADDR_W    = 32,
   parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              restart,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [2:0]        fmt,
   input  logic [6:0]        opcode,
   input  logic [2:0]        func3,
   input  logic [6:0]        func7,
   input  logic [4:0]        rd,
   input  logic [4:0]        rs1,
   input  logic [4:0]        rs2,
   input  logic [31:0]       imm,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [31:0]       out_instr,
   output logic [ADDR_W-1:0] out_addr,
   output logic              out_err,
   output logic [15:0]       err_count
);

   localparam logic [31:0] NOP = 32'h0000_0013;

   typedef enum logic {EMPTY, FULL} state_e;

   state_e              state_q;
   logic [31:0]         instr_q;
   logic [ADDR_W-1:0]   addr_q, cnt_q, tag;
   logic                err_q;
   logic [15:0]         errcnt_q;
   logic [31:0]         enc, instr_d;
   logic                bad, is_shift, accept, out_fire;

   assign out_valid = (state_q == FULL);
   assign in_ready  = !out_valid || out_ready;
   assign accept    = in_valid && in_ready;
   assign out_fire  = out_valid && out_ready;
   // restart outranks the counter for a bundle accepted in the same cycle
   assign tag       = restart ? BASE_ADDR : cnt_q;

   assign out_instr = instr_q;
   assign out_addr  = addr_q;
   assign out_err   = err_q;
   assign err_count = errcnt_q;

   always_comb begin
      is_shift = (opcode == 7'h13) && (func3 == 3'd1 || func3 == 3'd5);
      enc      = NOP;
      bad      = 1'b0;
      case (fmt)
         3'd0: enc = {func7, rs2, rs1, func3, rd, opcode};
         3'd1: begin
            if (is_shift) begin
               enc = {func7, imm[4:0], rs1, func3, rd, opcode};
               bad = |imm[31:5];
            end else begin
               enc = {imm[11:0], rs1, func3, rd, opcode};
               bad = !(&imm[31:11] || ~|imm[31:11]);
            end
         end
         3'd2: begin
            enc = {imm[11:5], rs2, rs1, func3, imm[4:0], opcode};
            bad = !(&imm[31:11] || ~|imm[31:11]);
         end
         3'd3: begin
            enc = {imm[12], imm[10:5], rs2, rs1, func3, imm[4:1], imm[11], opcode};
            bad = !(&imm[31:12] || ~|imm[31:12]) || imm[0];
         end
         3'd4: begin
            enc = {imm[31:12], rd, opcode};
            bad = |imm[11:0];
         end
         3'd5: begin
            enc = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
            bad = !(&imm[31:20] || ~|imm[31:20]) || imm[0];
         end
         default: bad = 1'b1;
      endcase
      instr_d = bad ? NOP : enc;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= EMPTY;
         instr_q  <= NOP;
         addr_q   <= BASE_ADDR;
         err_q    <= 1'b0;
         cnt_q    <= BASE_ADDR;
         errcnt_q <= '0;
      end else begin
         if (restart)
            errcnt_q <= '0;
         else if (out_fire && err_q && errcnt_q != 16'hFFFF)
            errcnt_q <= errcnt_q + 16'd1;

         if (accept) begin
            state_q <= FULL;
            instr_q <= instr_d;
            err_q   <= bad;
            addr_q  <= tag;
            cnt_q   <= tag + ADDR_W'(4);
         end else begin
            if (restart)  cnt_q   <= BASE_ADDR;
            if (out_fire) state_q <= EMPTY;
         end
      end
   end

endmodule
